fp_completion_arbiter: RTL and testbench

//  FPU-side responder for the pending FP ops queue. Collects out-of-order completions
//  (tag, data, fflags) from NUM_UNITS FP functional units (FMA, DIVSQRT, NONCOMP/CONV),

---
 rtl/fp_completion_arbiter_pkg.sv | 17 +
 rtl/fp_compl_fifo.sv | 45 ++++
 rtl/fp_completion_arbiter.sv | 110 +++++++++++
 tb/tb_fp_completion_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fp_completion_arbiter_pkg.sv
// fp_completion_arbiter_pkg: shared types and default sizing for the FP completion arbiter
package fp_completion_arbiter_pkg;
  localparam int TAG_W                 = 6;
  localparam int DATA_W                = 64;
  localparam int STATUS_W              = 5;
  localparam int FP_COMPL_NUM_UNITS    = 3;
  localparam int FP_COMPL_FIFO_DEPTH   = 2;
  localparam int FP_COMPL_MAX_INFLIGHT = 8;
  typedef logic [TAG_W-1:0]    reg_t;
  typedef logic [DATA_W-1:0]   bus64_t;
  typedef logic [STATUS_W-1:0] status_t;
  typedef struct packed {
    reg_t    tag;
    bus64_t  data;
    status_t status;
  } fp_compl_entry_t;
endpackage

// File: rtl/fp_compl_fifo.sv
// fp_compl_fifo: per-unit completion FIFO; ports clk_i/rstn_i, flush_i, push_i/data_i, pop_i/data_o (head), count_o, full_o, empty_o
module fp_compl_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign full_o  = r_count == CW'(DEPTH);
  assign empty_o = r_count == '0;
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd];
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk_i)
    if (w_push && !flush_i) r_mem[r_wr] <= data_i;
endmodule

// File: rtl/fp_completion_arbiter.sv
// fp_completion_arbiter: round-robin merge of per-unit FP completions into one result stream, with in-flight credit
//   in : clk_i, rstn_i (async, active-low), flush_i, issue_valid_i, unit_valid/tag/data/status_i (packed per unit)
//   out: issue_ready_o, unit_ready_o, result_valid/tag/data/fp_status_o, inflight_o
//   FP_COMPL_BYPASS_EN: drop the output register, results become combinational (latency 0)
module fp_completion_arbiter
  import fp_completion_arbiter_pkg::*;
#(
  parameter int NUM_UNITS    = FP_COMPL_NUM_UNITS,
  parameter int FIFO_DEPTH   = FP_COMPL_FIFO_DEPTH,
  parameter int MAX_INFLIGHT = FP_COMPL_MAX_INFLIGHT
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              flush_i,
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  input  logic [NUM_UNITS-1:0]              unit_valid_i,
  input  logic [NUM_UNITS*TAG_W-1:0]        unit_tag_i,
  input  logic [NUM_UNITS*DATA_W-1:0]       unit_data_i,
  input  logic [NUM_UNITS*STATUS_W-1:0]     unit_status_i,
  output logic [NUM_UNITS-1:0]              unit_ready_o,
  output logic                              result_valid_o,
  output logic [TAG_W-1:0]                  result_tag_o,
  output logic [DATA_W-1:0]                 result_data_o,
  output logic [STATUS_W-1:0]               result_fp_status_o,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight_o
);
  localparam int PW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  fp_compl_entry_t             w_live [NUM_UNITS];
  fp_compl_entry_t             w_head [NUM_UNITS];
  fp_compl_entry_t             w_cand_e [NUM_UNITS];
  fp_compl_entry_t             w_win_e;
  logic [CW-1:0]               w_count [NUM_UNITS];
  logic [NUM_UNITS-1:0]        w_empty, w_full, w_cand, w_push, w_pop;
  logic [PW-1:0]               r_rr, w_win;
  logic                        w_found, w_valid, w_inc, w_dec;
  logic [IW-1:0]               r_inflight;
  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
    assign w_live[k]       = {unit_tag_i[k*TAG_W +: TAG_W], unit_data_i[k*DATA_W +: DATA_W],
                              unit_status_i[k*STATUS_W +: STATUS_W]};
    // An empty FIFO lets the live completion compete directly, giving latency 1 (0 in bypass)
    assign w_cand[k]       = ~w_empty[k] | unit_valid_i[k];
    assign w_cand_e[k]     = w_empty[k] ? w_live[k] : w_head[k];
    assign unit_ready_o[k] = w_count[k] < CW'(FIFO_DEPTH);
    assign w_pop[k]        = w_found & (w_win == PW'(k)) & ~w_empty[k] & ~flush_i;
    // A live completion that wins arbitration goes straight out and is not enqueued
    assign w_push[k]       = unit_valid_i[k] & unit_ready_o[k] & ~flush_i &
                             ~(w_found & (w_win == PW'(k)) & w_empty[k]);
    fp_compl_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fp_compl_entry_t))) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .flush_i (flush_i),
      .push_i  (w_push[k]),
      .pop_i   (w_pop[k]),
      .data_i  (w_live[k]),
      .data_o  (w_head[k]),
      .count_o (w_count[k]),
      .full_o  (w_full[k]),
      .empty_o (w_empty[k])
    );
  end
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (!w_found && w_cand[(int'(r_rr) + i) % NUM_UNITS]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_rr) + i) % NUM_UNITS);
      end
  end
  assign w_win_e       = w_cand_e[w_win];
  assign w_valid       = w_found & ~flush_i;
  assign issue_ready_o = r_inflight < IW'(MAX_INFLIGHT);
  assign inflight_o    = r_inflight;
  assign w_inc         = issue_valid_i & issue_ready_o;
  assign w_dec         = result_valid_o;
`ifdef FP_COMPL_BYPASS_EN
  assign result_valid_o = w_valid;
  assign {result_tag_o, result_data_o, result_fp_status_o} = w_valid ? w_win_e : '0;
`else
  fp_compl_entry_t r_out;
  logic            r_valid;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else begin
      r_valid <= w_valid;
      r_out   <= w_valid ? w_win_e : '0;
    end
  assign result_valid_o = r_valid;
  assign {result_tag_o, result_data_o, result_fp_status_o} = r_out;
`endif
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_rr       <= '0;
      r_inflight <= '0;
    end else if (flush_i) begin
      r_rr       <= '0;
      r_inflight <= '0;
    end else begin
      if (w_found) r_rr <= (w_win == PW'(NUM_UNITS - 1)) ? '0 : w_win + 1'b1;
      if (w_inc && !w_dec) r_inflight <= r_inflight + 1'b1;
      else if (w_dec && !w_inc && r_inflight != '0) r_inflight <= r_inflight - 1'b1;
    end
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rstn_i || flush_i)
    !(w_dec && !w_inc && r_inflight == '0));
endmodule

// File: tb/tb_fp_completion_arbiter.sv
// tb_fp_completion_arbiter: directed vector bench for fp_completion_arbiter
module tb_fp_completion_arbiter;
  import fp_completion_arbiter_pkg::*;
  logic        clk_i = 1'b0, rstn_i = 1'b0, flush_i = 1'b0, issue_valid_i = 1'b0;
  logic [2:0]  unit_valid_i = '0;
  logic [17:0] unit_tag_i = '0;
  logic [191:0] unit_data_i = '0;
  logic [14:0] unit_status_i = '0;
  logic        issue_ready_o, result_valid_o;
  logic [2:0]  unit_ready_o;
  logic [5:0]  result_tag_o;
  logic [63:0] result_data_o;
  logic [4:0]  result_fp_status_o;
  logic [3:0]  inflight_o;
  int checks = 0, failures = 0;
  fp_completion_arbiter dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .unit_valid_i(unit_valid_i), .unit_tag_i(unit_tag_i), .unit_data_i(unit_data_i),
    .unit_status_i(unit_status_i), .unit_ready_o(unit_ready_o),
    .result_valid_o(result_valid_o), .result_tag_o(result_tag_o), .result_data_o(result_data_o),
    .result_fp_status_o(result_fp_status_o), .inflight_o(inflight_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic iss, fl;
    logic [2:0] uv;
    logic [5:0] t0, t1, t2;
    logic ev;
    logic [5:0] et;
    logic [3:0] einf;
    logic eri;
    logic [2:0] eur;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] mk_data(input logic [5:0] t);
    return {8'h40, 50'h0, t};
  endfunction
  function automatic logic [4:0] mk_st(input logic [5:0] t);
    return t[4:0] ^ 5'h15;
  endfunction
  function automatic void add(input logic iss, fl, input logic [2:0] uv, input logic [5:0] t0, t1, t2,
                              input logic ev, input logic [5:0] et, input logic [3:0] einf,
                              input logic eri, input logic [2:0] eur);
    vq.push_back('{iss, fl, uv, t0, t1, t2, ev, et, einf, eri, eur});
  endfunction
  task automatic drive(input logic iss, fl, input logic [2:0] uv, input logic [5:0] t0, t1, t2);
    issue_valid_i = iss;
    flush_i       = fl;
    unit_valid_i  = uv;
    unit_tag_i    = {t2, t1, t0};
    unit_data_i   = {mk_data(t2), mk_data(t1), mk_data(t0)};
    unit_status_i = {mk_st(t2), mk_st(t1), mk_st(t0)};
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset valid", 64'(result_valid_o), 64'd0);
    chk("reset tag", 64'(result_tag_o), 64'd0);
    chk("reset data", result_data_o, 64'd0);
    chk("reset status", 64'(result_fp_status_o), 64'd0);
    chk("reset inflight", 64'(inflight_o), 64'd0);
    chk("reset issue_ready", 64'(issue_ready_o), 64'd1);
    chk("reset unit_ready", 64'(unit_ready_o), 64'd7);
    @(negedge clk_i);
    rstn_i = 1'b1;
`ifdef FP_COMPL_BYPASS_EN
    @(negedge clk_i);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    chk("byp inflight 1", 64'(inflight_o), 64'd1);
    @(negedge clk_i);
    drive(0, 0, 3'b100, 0, 0, 9);
    #1;
    chk("byp valid", 64'(result_valid_o), 64'd1);
    chk("byp tag", 64'(result_tag_o), 64'd9);
    chk("byp data", result_data_o, mk_data(6'd9));
    @(posedge clk_i);
    #1;
    chk("byp inflight 0", 64'(inflight_o), 64'd0);
    chk("byp unit_ready", 64'(unit_ready_o), 64'd7);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("byp idle valid", 64'(result_valid_o), 64'd0);
    chk("byp idle tag", 64'(result_tag_o), 64'd0);
`else
    @(negedge clk_i);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    chk("t1 inflight 1", 64'(inflight_o), 64'd1);
    @(negedge clk_i);
    drive(0, 0, 3'b001, 3, 0, 0);
    unit_data_i[63:0]  = 64'h4000_0000_0000_0000;
    unit_status_i[4:0] = 5'h01;
    @(posedge clk_i);
    #1;
    chk("t1 valid", 64'(result_valid_o), 64'd1);
    chk("t1 tag", 64'(result_tag_o), 64'd3);
    chk("t1 data", result_data_o, 64'h4000_0000_0000_0000);
    chk("t1 status", 64'(result_fp_status_o), 64'h01);
    chk("t1 inflight still 1", 64'(inflight_o), 64'd1);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    chk("t1 valid pulse", 64'(result_valid_o), 64'd0);
    chk("t1 data idle", result_data_o, 64'd0);
    chk("t1 inflight 0", 64'(inflight_o), 64'd0);
    // collision, starting from rr 0 after flush
    add(0,1,0, 0,0,0,   0,0, 0,1,7);
    add(1,0,0, 0,0,0,   0,0, 1,1,7);
    add(1,0,0, 0,0,0,   0,0, 2,1,7);
    add(1,0,0, 0,0,0,   0,0, 3,1,7);
    add(0,0,7, 5,6,7,   1,5, 3,1,7);
    add(0,0,0, 0,0,0,   1,6, 2,1,7);
    add(0,0,0, 0,0,0,   1,7, 1,1,7);
    add(0,0,0, 0,0,0,   0,0, 0,1,7);
    // rr back at 0: unit0 must beat unit1
    add(1,0,0, 0,0,0,   0,0, 1,1,7);
    add(1,0,0, 0,0,0,   0,0, 2,1,7);
    add(0,0,3, 10,11,0, 1,10,2,1,7);
    add(0,0,0, 0,0,0,   1,11,1,1,7);
    add(0,0,0, 0,0,0,   0,0, 0,1,7);
    // backpressure on unit1 while unit0 streams (rr starts at 2)
    for (int i = 1; i <= 6; i++) add(1,0,0, 0,0,0, 0,0, 4'(i),1,7);
    add(0,0,3, 20,30,0, 1,20,6,1,7);
    add(0,0,3, 21,31,0, 1,30,5,1,7);
    add(0,0,3, 22,32,0, 1,21,4,1,5);
    add(0,0,0, 0,0,0,   1,31,3,1,7);
    add(0,0,0, 0,0,0,   1,22,2,1,7);
    add(0,0,0, 0,0,0,   1,32,1,1,7);
    add(0,0,0, 0,0,0,   0,0, 0,1,7);
    // credit limit
    for (int i = 1; i <= 8; i++) add(1,0,0, 0,0,0, 0,0, 4'(i), i < 8, 7);
    add(1,0,0, 0,0,0,   0,0, 8,0,7);
    add(0,0,4, 0,0,40,  1,40,8,0,7);
    add(0,0,4, 0,0,41,  1,41,7,1,7);
    add(1,0,0, 0,0,0,   0,0, 7,1,7);
    add(0,0,0, 0,0,0,   0,0, 7,1,7);
    // flush with two entries buffered and a live unit0 completion
    add(0,0,7, 50,51,52,1,50,7,1,7);
    add(1,1,1, 53,0,0,  0,0, 0,1,7);
    add(0,0,0, 0,0,0,   0,0, 0,1,7);
    add(0,0,0, 0,0,0,   0,0, 0,1,7);
    add(1,0,0, 0,0,0,   0,0, 1,1,7);
    add(1,0,0, 0,0,0,   0,0, 2,1,7);
    add(0,0,6, 0,61,62, 1,61,2,1,7);
    add(0,0,0, 0,0,0,   1,62,1,1,7);
    add(0,0,0, 0,0,0,   0,0, 0,1,7);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_i);
      drive(vq[i].iss, vq[i].fl, vq[i].uv, vq[i].t0, vq[i].t1, vq[i].t2);
      @(posedge clk_i);
      #1;
      chk($sformatf("row%0d valid", i), 64'(result_valid_o), 64'(vq[i].ev));
      chk($sformatf("row%0d tag", i), 64'(result_tag_o), vq[i].ev ? 64'(vq[i].et) : 64'd0);
      chk($sformatf("row%0d data", i), result_data_o, vq[i].ev ? mk_data(vq[i].et) : 64'd0);
      chk($sformatf("row%0d status", i), 64'(result_fp_status_o), vq[i].ev ? 64'(mk_st(vq[i].et)) : 64'd0);
      chk($sformatf("row%0d inflight", i), 64'(inflight_o), 64'(vq[i].einf));
      chk($sformatf("row%0d issue_ready", i), 64'(issue_ready_o), 64'(vq[i].eri));
      chk($sformatf("row%0d unit_ready", i), 64'(unit_ready_o), 64'(vq[i].eur));
    end
    // asynchronous reset while a result is being presented
    @(negedge clk_i);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    drive(0, 0, 3'b001, 6'd42, 0, 0);
    @(posedge clk_i);
    #1;
    chk("arst pre valid", 64'(result_valid_o), 64'd1);
    chk("arst pre tag", 64'(result_tag_o), 64'd42);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("arst valid", 64'(result_valid_o), 64'd0);
    chk("arst tag", 64'(result_tag_o), 64'd0);
    chk("arst inflight", 64'(inflight_o), 64'd0);
    chk("arst issue_ready", 64'(issue_ready_o), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
`endif
    repeat (2) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
